jtag_tap_ctrl: RTL and testbench

- IEEE 1149.1-style TAP controller that drives a chain of BC_2 boundary scan cells.
- Contains a 16-state TAP FSM, instruction register, bypass register and IDCODE register.
- Generates the cell controls (shift_dr, capture_en, update_en, mode) and accepts the chain's serial output on so.
- Cells are used synchronously: integration ties their capture_clk and update_clk to tck.

---
 rtl/jtag_tap_ctrl.sv | 93 +++++++++
 tb/tb_jtag_tap_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_ctrl.sv
// jtag_tap_ctrl: IEEE 1149.1 TAP controller with IR, bypass and IDCODE registers driving a BC_2 boundary chain
module jtag_tap_ctrl #(
    parameter int                  IR_WIDTH    = 4,
    parameter logic [IR_WIDTH-1:0] SAMPLE_CODE = IR_WIDTH'(1),
    parameter logic [IR_WIDTH-1:0] IDCODE_CODE = IR_WIDTH'(2),
    parameter logic [31:0]         IDCODE_VAL  = 32'h1000_0001
) (
    input  logic       tck,
    input  logic       trst,
    input  logic       tms,
    input  logic       tdi,
    input  logic       so,
    output logic       tdo,
    output logic       tdo_en,
    output logic       shift_dr,
    output logic       capture_en,
    output logic       update_en,
    output logic       mode,
    output logic [3:0] tap_state
);
    typedef enum logic [3:0] {
        TLR    = 4'hF, RTI    = 4'hC, SEL_DR = 4'h7, CAP_DR = 4'h6,
        SH_DR  = 4'h2, EX1_DR = 4'h1, PAU_DR = 4'h3, EX2_DR = 4'h0,
        UPD_DR = 4'h5, SEL_IR = 4'h4, CAP_IR = 4'hE, SH_IR  = 4'hA,
        EX1_IR = 4'h9, PAU_IR = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD
    } state_t;

    state_t              state_q, state_d;
    logic [IR_WIDTH-1:0] ir_latch_q, ir_latch_d, ir_shift_q, ir_shift_d;
    logic                bypass_q, bypass_d;
    logic [31:0]         idcode_q, idcode_d;
    logic                is_extest, is_sample, is_idcode, boundary;

    always_comb begin
        state_d = TLR;
        unique case (state_q)
            TLR:            state_d = tms ? TLR    : RTI;
            RTI:            state_d = tms ? SEL_DR : RTI;
            SEL_DR:         state_d = tms ? SEL_IR : CAP_DR;
            SEL_IR:         state_d = tms ? TLR    : CAP_IR;
            CAP_DR, SH_DR:  state_d = tms ? EX1_DR : SH_DR;
            EX1_DR:         state_d = tms ? UPD_DR : PAU_DR;
            PAU_DR:         state_d = tms ? EX2_DR : PAU_DR;
            EX2_DR:         state_d = tms ? UPD_DR : SH_DR;
            CAP_IR, SH_IR:  state_d = tms ? EX1_IR : SH_IR;
            EX1_IR:         state_d = tms ? UPD_IR : PAU_IR;
            PAU_IR:         state_d = tms ? EX2_IR : PAU_IR;
            EX2_IR:         state_d = tms ? UPD_IR : SH_IR;
            UPD_DR, UPD_IR: state_d = tms ? SEL_DR : RTI;
            default:        state_d = TLR;
        endcase
    end

    always_comb begin
        ir_shift_d = state_q == CAP_IR ? IR_WIDTH'(1)
                   : state_q == SH_IR  ? {tdi, ir_shift_q[IR_WIDTH-1:1]} : ir_shift_q;
        ir_latch_d = state_d == TLR    ? IDCODE_CODE
                   : state_q == UPD_IR ? ir_shift_q : ir_latch_q;
        bypass_d   = state_q == CAP_DR ? 1'b0 : state_q == SH_DR ? tdi : bypass_q;
        idcode_d   = state_q == CAP_DR ? IDCODE_VAL
                   : state_q == SH_DR  ? {tdi, idcode_q[31:1]} : idcode_q;
    end

    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            state_q    <= TLR;
            ir_latch_q <= IDCODE_CODE;
            ir_shift_q <= '0;
            bypass_q   <= 1'b0;
            idcode_q   <= IDCODE_VAL;
        end else begin
            state_q    <= state_d;
            ir_latch_q <= ir_latch_d;
            ir_shift_q <= ir_shift_d;
            bypass_q   <= bypass_d;
            idcode_q   <= idcode_d;
        end
    end

    // Any opcode not otherwise decoded falls through to BYPASS
    assign is_extest  = ir_latch_q == '0;
    assign is_sample  = ir_latch_q == SAMPLE_CODE;
    assign is_idcode  = ir_latch_q == IDCODE_CODE;
    assign boundary   = is_extest | is_sample;
    assign tap_state  = state_q;
    assign shift_dr   = state_q == SH_DR;
    assign tdo_en     = shift_dr | (state_q == SH_IR);
    assign capture_en = !(boundary && (state_q == CAP_DR || state_q == SH_DR));
    assign update_en  = boundary && state_q == UPD_DR;
    assign mode       = is_extest;
    assign tdo        = state_q == SH_IR ? ir_shift_q[0]
                      : shift_dr ? (boundary ? so : is_idcode ? idcode_q[0] : bypass_q) : 1'b0;
endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// tb_jtag_tap_ctrl: randomized TAP walks checked against a table-driven reference model with a 1-cell BC_2 chain
module tb_jtag_tap_ctrl;
    localparam int          IRW  = 4;
    localparam logic [31:0] IDV  = 32'h1000_0001;
    localparam int S_TLR = 15, S_RTI = 12, S_CAPDR = 6, S_SHDR = 2, S_UPDDR = 5;
    localparam int S_CAPIR = 14, S_SHIR = 10, S_UPDIR = 13;

    logic tck = 0, trst = 1, tms = 1, tdi = 0, data_in = 0;
    logic cell_cap = 0, cell_upd = 0;
    logic so, data_out;
    logic tdo, tdo_en, shift_dr, capture_en, update_en, mode;
    logic [3:0] tap_state;

    int errors = 0, checks = 0;

    // next-state tables indexed by state code: n0 for tms=0, n1 for tms=1
    int n0[16] = '{2, 3, 2, 3, 14, 12, 2, 6, 10, 11, 10, 11, 12, 12, 10, 12};
    int n1[16] = '{5, 5, 1, 0, 15, 7, 1, 4, 13, 13, 9, 8, 7, 7, 9, 15};

    int          m_state;
    logic [3:0]  m_ir, m_sh;
    logic        m_byp, m_cell, m_upd;
    logic [31:0] m_id;

    logic [IRW-1:0] ir_obs;
    logic           mode_upd;
    logic [63:0]    dr_obs;

    jtag_tap_ctrl dut (
        .tck(tck), .trst(trst), .tms(tms), .tdi(tdi), .so(so),
        .tdo(tdo), .tdo_en(tdo_en), .shift_dr(shift_dr), .capture_en(capture_en),
        .update_en(update_en), .mode(mode), .tap_state(tap_state)
    );

    always #5 tck = ~tck;

    assign so       = cell_cap;
    assign data_out = mode ? cell_upd : data_in;

    always @(posedge tck) begin
        if (!capture_en) cell_cap <= shift_dr ? tdi : data_in;
        if (update_en) cell_upd <= cell_cap;
    end

    function automatic int instr();
        return m_ir == 4'd0 ? 0 : m_ir == 4'd1 ? 1 : m_ir == 4'd2 ? 2 : 3;
    endfunction

    function automatic logic [10:0] expv();
        logic bnd, sd, si, md;
        bnd = instr() < 2;
        sd  = m_state == S_SHDR;
        si  = m_state == S_SHIR;
        md  = instr() == 0;
        return {4'(m_state),
                si ? m_sh[0] : sd ? (bnd ? m_cell : instr() == 2 ? m_id[0] : m_byp) : 1'b0,
                sd | si, sd,
                !(bnd && (m_state == S_CAPDR || sd)),
                bnd && m_state == S_UPDDR, md,
                md ? m_upd : data_in};
    endfunction

    task automatic model_reset();
        m_state = S_TLR;
        m_ir    = 4'd2;
        m_sh    = 4'd0;
        m_byp   = 1'b0;
        m_id    = IDV;
    endtask

    task automatic model_update();
        int  nxt;
        logic bnd;
        bnd = instr() < 2;
        nxt = tms ? n1[m_state] : n0[m_state];
        if (m_state == S_CAPIR) m_sh = 4'd1;
        if (m_state == S_SHIR)  m_sh = {tdi, m_sh[3:1]};
        if (m_state == S_UPDIR) m_ir = m_sh;
        if (m_state == S_CAPDR) begin
            m_byp = 1'b0;
            m_id  = IDV;
            if (bnd) m_cell = data_in;
        end
        if (m_state == S_SHDR) begin
            m_byp = tdi;
            m_id  = {tdi, m_id[31:1]};
            if (bnd) m_cell = tdi;
        end
        if (m_state == S_UPDDR && bnd) m_upd = m_cell;
        if (nxt == S_TLR) m_ir = 4'd2;
        m_state = nxt;
    endtask

    task automatic step(input logic t, input logic d);
        tms = t;
        tdi = d;
        @(posedge tck);
        model_update();
        @(negedge tck);
    endtask

    task automatic load_ir(input logic [IRW-1:0] code);
        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        for (int i = 0; i < IRW; i++) begin
            ir_obs[i] = tdo;
            step(i == IRW - 1, code[i]);
        end
        step(1, 0);
        mode_upd = mode;
        step(0, 0);
    endtask

    task automatic scan_dr(input int n, input logic [63:0] data);
        step(1, 0); step(0, 0); step(0, 0);
        dr_obs = '0;
        for (int i = 0; i < n; i++) begin
            dr_obs[i] = tdo;
            step(i == n - 1, data[i]);
        end
        step(1, 0); step(0, 0);
    endtask

    task automatic test_reset();
        @(negedge tck);
        model_reset();
        checks++;
        if ({tdo, tdo_en, shift_dr, capture_en, update_en, mode, tap_state} !== {6'b000100, 4'hF}) begin
            errors++;
            $display("FAIL reset_outputs: got %b required %b",
                     {tdo, tdo_en, shift_dr, capture_en, update_en, mode, tap_state}, {6'b000100, 4'hF});
        end
        trst = 0;
        step(0, 0);
        checks++;
        if (tap_state !== 4'hC) begin
            errors++;
            $display("FAIL reset_to_rti: got %h required c", tap_state);
        end
    endtask

    task automatic test_idcode();
        scan_dr(32, 64'($urandom));
        checks++;
        if (dr_obs[31:0] !== IDV) begin
            errors++;
            $display("FAIL idcode_stream: got %h required %h", dr_obs[31:0], IDV);
        end
    endtask

    task automatic test_extest_ir();
        load_ir(4'b0000);
        checks++;
        if (ir_obs !== 4'b0001) begin
            errors++;
            $display("FAIL ir_capture: got %b required 0001", ir_obs);
        end
        checks++;
        if ({mode_upd, mode} !== 2'b01) begin
            errors++;
            $display("FAIL mode_edge: got upd=%b after=%b required 0 then 1", mode_upd, mode);
        end
    endtask

    task automatic test_bypass();
        logic [63:0] d;
        load_ir(4'b1111);
        scan_dr(4, 64'b1011);
        checks++;
        if (dr_obs[3:0] !== 4'b0110) begin
            errors++;
            $display("FAIL bypass_1011: got %b required 0110", dr_obs[3:0]);
        end
        d = {$urandom, $urandom};
        scan_dr(20, d);
        checks++;
        if (dr_obs[19:0] !== {d[18:0], 1'b0}) begin
            errors++;
            $display("FAIL bypass_random: got %h required %h", dr_obs[19:0], {d[18:0], 1'b0});
        end
    endtask

    task automatic test_sample();
        load_ir(4'b0001);
        data_in = 1;
        step(1, 0);
        checks++;
        if (capture_en !== 1'b1) begin
            errors++;
            $display("FAIL sample_seldr_cap: got %b required 1", capture_en);
        end
        step(0, 0);
        checks++;
        if (capture_en !== 1'b0) begin
            errors++;
            $display("FAIL sample_capdr_cap: got %b required 0", capture_en);
        end
        step(0, 0);
        checks++;
        if ({capture_en, shift_dr, tdo} !== 3'b011) begin
            errors++;
            $display("FAIL sample_shdr: got cap/shift/tdo=%b required 011", {capture_en, shift_dr, tdo});
        end
        step(1, 1);
        step(1, 0);
        checks++;
        if ({update_en, mode} !== 2'b10) begin
            errors++;
            $display("FAIL sample_upd: got upd/mode=%b required 10", {update_en, mode});
        end
        step(0, 0);
        checks++;
        if (data_out !== data_in) begin
            errors++;
            $display("FAIL sample_transparent: got %b required %b", data_out, data_in);
        end
    endtask

    task automatic test_extest_update();
        load_ir(4'b0000);
        for (int k = 0; k < 2; k++) begin
            logic v;
            v = (k == 0);
            data_in = 1;
            step(1, 0); step(0, 0); step(0, 0);
            step(1, v);
            step(1, 0);
            checks++;
            if (update_en !== 1'b1) begin
                errors++;
                $display("FAIL extest_upd_on %0d: got %b required 1", k, update_en);
            end
            step(0, 0);
            checks++;
            if ({update_en, data_out} !== {1'b0, v}) begin
                errors++;
                $display("FAIL extest_data_out %0d: got upd/out=%b required %b", k, {update_en, data_out}, {1'b0, v});
            end
        end
    endtask

    task automatic test_tlr_reset();
        for (int k = 0; k < 4; k++) begin
            load_ir(4'b0000);
            repeat ($urandom_range(0, 12)) step(1'($urandom), 1'($urandom));
            repeat (5) step(1, 1'($urandom));
            checks++;
            if ({tap_state, mode} !== {4'hF, 1'b0}) begin
                errors++;
                $display("FAIL tlr_5tms %0d: got state=%h mode=%b required f 0", k, tap_state, mode);
            end
        end
        step(0, 0);
        scan_dr(32, 64'($urandom));
        checks++;
        if (dr_obs[31:0] !== IDV) begin
            errors++;
            $display("FAIL tlr_idcode: got %h required %h", dr_obs[31:0], IDV);
        end
    endtask

    task automatic test_reset_midscan();
        load_ir(4'b0000);
        step(1, 0); step(0, 0); step(0, 1); step(0, 0);
        checks++;
        if ({tap_state, capture_en, mode} !== {4'h2, 2'b01}) begin
            errors++;
            $display("FAIL midscan_pre: got %h/%b required 2/01", tap_state, {capture_en, mode});
        end
        #2 trst = 1;
        #1;
        model_reset();
        checks++;
        if ({tap_state, capture_en, mode, tdo_en} !== {4'hF, 3'b100}) begin
            errors++;
            $display("FAIL midscan_reset: got %h/%b required f/100", tap_state, {capture_en, mode, tdo_en});
        end
        #1 trst = 0;
        step(0, 0);
        checks++;
        if ({tap_state, data_out} !== {4'hC, data_in}) begin
            errors++;
            $display("FAIL midscan_rti: got %h/%b required c/%b", tap_state, data_out, data_in);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            checks++;
            if ({tap_state, tdo, tdo_en, shift_dr, capture_en, update_en, mode, data_out} !== expv()) begin
                errors++;
                $display("FAIL random_walk %0d: got %b required %b", i,
                         {tap_state, tdo, tdo_en, shift_dr, capture_en, update_en, mode, data_out}, expv());
            end
            data_in = 1'($urandom);
            step($urandom_range(0, 9) < 4, 1'($urandom));
        end
    endtask

    initial begin
        m_cell = 0;
        m_upd  = 0;
        model_reset();
        test_reset();
        test_idcode();
        test_extest_ir();
        test_bypass();
        test_sample();
        test_extest_update();
        test_tlr_reset();
        test_reset_midscan();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
